// File: rtl/sc_mmio_pkg.sv
// Shared constants for the single-cycle data memory with memory-mapped I/O:
// I/O region codes, the I/O select bit and the active-low 7-segment table.
package sc_mmio_pkg;

  localparam logic [1:0] REG_IN   = 2'b00;
  localparam logic [1:0] REG_OUT  = 2'b01;
  localparam logic [1:0] REG_STAT = 2'b10;
  localparam logic [1:0] REG_RSVD = 2'b11;

  localparam int IO_SEL_BIT = 7;

  // Active-low {g,f,e,d,c,b,a}; entry 0 sits in the low bits.
  localparam logic [15:0][6:0] SEG7_LUT = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [6:0] seg7_of(input logic [3:0] hex);
    return SEG7_LUT[hex];
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to active-low 7-segment pattern, one per display digit.
module hex_to_seg7
  import sc_mmio_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = seg7_of(hex);

endmodule

// File: rtl/sc_datamem_mmio.sv
// Word RAM plus memory-mapped input ports, display registers and a sticky
// clear-on-read input-change status register. Optional SC_MMIO_BYTE_WRITE_EN.
module sc_datamem_mmio
  import sc_mmio_pkg::*;
#(
  parameter int DEPTH_LOG2   = 5,
  parameter int IN_CHANNELS  = 2,
  parameter int IN_WIDTH     = 5,
  parameter int OUT_CHANNELS = 3
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [31:0]                     addr,
  input  logic [31:0]                     datain,
  input  logic                            we,
  input  logic                            re,
  input  logic [3:0]                      be,
  output logic [31:0]                     dataout,
  input  logic [IN_CHANNELS*IN_WIDTH-1:0] in_port,
  output logic [OUT_CHANNELS*14-1:0]      seg_out,
  output logic                            irq
);

  localparam int IW = IN_CHANNELS * IN_WIDTH;

  logic                  io_sel_s;
  logic [1:0]            region_s;
  logic [2:0]            idx_s;
  logic [DEPTH_LOG2-1:0] ram_idx_s;
  logic                  ram_we_s;
  logic                  out_we_s;
  logic                  clr_s;
  logic [31:0]           rd_s;
  logic                  unused_s;

  logic [31:0]            mem_r [2**DEPTH_LOG2];
  logic [IW-1:0]          s1_r, s2_r, prev_r;
  logic [IN_CHANNELS-1:0] status_r, status_nxt_s, set_s;
  logic [7:0]             out_r [OUT_CHANNELS];
  logic [31:0]            in_word_s  [8];
  logic [31:0]            out_word_s [8];

  assign io_sel_s  = addr[IO_SEL_BIT];
  assign region_s  = addr[6:5];
  assign idx_s     = addr[4:2];
  assign ram_idx_s = addr[DEPTH_LOG2+1:2];
  assign ram_we_s  = we && !io_sel_s;
`ifdef SC_MMIO_BYTE_WRITE_EN
  assign out_we_s  = we && io_sel_s && (region_s == REG_OUT) && be[0];
`else
  assign out_we_s  = we && io_sel_s && (region_s == REG_OUT);
`endif
  assign clr_s     = re && io_sel_s && (region_s == REG_STAT) && (idx_s == 3'd0);
  assign unused_s  = ^{addr[31:8], addr[1:0], be};

  // Word RAM: no reset, stores commit on the rising edge.
  always_ff @(posedge clock) begin
    if (ram_we_s) begin
`ifdef SC_MMIO_BYTE_WRITE_EN
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_r[ram_idx_s][b*8 +: 8] <= datain[b*8 +: 8];
      end
`else
      mem_r[ram_idx_s] <= datain;
`endif
    end
  end

  // Per-channel change detect and zero-extended read words; unused slots read 0.
  for (genvar c = 0; c < 8; c++) begin : g_chan
    if (c < IN_CHANNELS) begin : g_in
      assign set_s[c]     = s2_r[c*IN_WIDTH +: IN_WIDTH] != prev_r[c*IN_WIDTH +: IN_WIDTH];
      assign in_word_s[c] = 32'(s2_r[c*IN_WIDTH +: IN_WIDTH]);
    end else begin : g_in_none
      assign in_word_s[c] = 32'd0;
    end
    if (c < OUT_CHANNELS) begin : g_out
      assign out_word_s[c] = 32'(out_r[c]);
      hex_to_seg7 u_hi (.hex(out_r[c][7:4]), .seg(seg_out[c*14+7 +: 7]));
      hex_to_seg7 u_lo (.hex(out_r[c][3:0]), .seg(seg_out[c*14 +: 7]));
    end else begin : g_out_none
      assign out_word_s[c] = 32'd0;
    end
  end

  // Clear-on-read drops every flag except those setting on the same edge.
  always_comb begin
    status_nxt_s = status_r;
    if (clr_s) begin
      status_nxt_s = set_s;
    end else begin
      status_nxt_s = status_r | set_s;
    end
  end

  // Input synchroniser, previous-value register and sticky status.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_r     <= '0;
      s2_r     <= '0;
      prev_r   <= '0;
      status_r <= '0;
    end else begin
      s1_r     <= in_port;
      s2_r     <= s1_r;
      prev_r   <= s2_r;
      status_r <= status_nxt_s;
    end
  end

  // Display registers; out-of-range indices match no register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < OUT_CHANNELS; c++) out_r[c] <= 8'd0;
    end else begin
      for (int c = 0; c < OUT_CHANNELS; c++) begin
        if (out_we_s && (idx_s == 3'(c))) out_r[c] <= datain[7:0];
      end
    end
  end

  // Combinational load mux.
  always_comb begin
    rd_s = 32'd0;
    if (!io_sel_s) begin
      rd_s = mem_r[ram_idx_s];
    end else begin
      case (region_s)
        REG_IN:   rd_s = in_word_s[idx_s];
        REG_OUT:  rd_s = out_word_s[idx_s];
        REG_STAT: rd_s = (idx_s == 3'd0) ? 32'(status_r) : 32'd0;
        REG_RSVD: rd_s = 32'd0;
        default:  rd_s = 32'd0;
      endcase
    end
  end

  assign dataout = rd_s;
  assign irq     = |status_r;

endmodule

// File: tb/tb_sc_datamem_mmio.sv
// Scoreboard bench for sc_datamem_mmio: stimulus pushes expected load results,
// a negedge monitor pops and compares them against the DUT.
module tb_sc_datamem_mmio;

  typedef struct {
    string       name;
    logic [31:0] data;
    bit          chk_irq;
    logic        irq;
    bit          chk_seg;
    logic [41:0] seg;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] addr, datain, dataout;
  logic        we, re, irq;
  logic [3:0]  be;
  logic [9:0]  in_port;
  logic [41:0] seg_out;

  exp_t sb[$];
  logic req;
  int   checks = 0;
  int   failures = 0;
  logic [7:0]  o0, o1, o2;
  logic [31:0] ram_0c;

  sc_datamem_mmio #(.DEPTH_LOG2(5), .IN_CHANNELS(2), .IN_WIDTH(5), .OUT_CHANNELS(3)) dut (
    .clock(clock), .reset(reset), .addr(addr), .datain(datain), .we(we), .re(re),
    .be(be), .dataout(dataout), .in_port(in_port), .seg_out(seg_out), .irq(irq)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] s7(input logic [3:0] h);
    case (h)
      4'h0: s7 = 7'b1000000;  4'h1: s7 = 7'b1111001;
      4'h2: s7 = 7'b0100100;  4'h3: s7 = 7'b0110000;
      4'h4: s7 = 7'b0011001;  4'h5: s7 = 7'b0010010;
      4'h6: s7 = 7'b0000010;  4'h7: s7 = 7'b1111000;
      4'h8: s7 = 7'b0000000;  4'h9: s7 = 7'b0010000;
      4'hA: s7 = 7'b0001000;  4'hB: s7 = 7'b0000011;
      4'hC: s7 = 7'b1000110;  4'hD: s7 = 7'b0100001;
      4'hE: s7 = 7'b0000110;  4'hF: s7 = 7'b0001110;
      default: s7 = 7'b1111111;
    endcase
  endfunction

  function automatic logic [41:0] segs(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return {s7(c[7:4]), s7(c[3:0]), s7(b[7:4]), s7(b[3:0]), s7(a[7:4]), s7(a[3:0])};
  endfunction

  // Monitor: one expected record per presented load.
  always @(negedge clock) begin
    exp_t e;
    if (req) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_underflow: load presented with no expected entry");
      end else begin
        e = sb.pop_front();
        checks++;
        if (dataout !== e.data) begin
          failures++;
          $display("FAIL %s dataout: got %h required %h", e.name, dataout, e.data);
        end
        if (e.chk_irq) begin
          checks++;
          if (irq !== e.irq) begin
            failures++;
            $display("FAIL %s irq: got %b required %b", e.name, irq, e.irq);
          end
        end
        if (e.chk_seg) begin
          checks++;
          if (seg_out !== e.seg) begin
            failures++;
            $display("FAIL %s seg_out: got %h required %h", e.name, seg_out, e.seg);
          end
        end
      end
    end
  end

  task automatic rd(input string nm, input logic [31:0] a, input logic r, input logic [31:0] d,
                    input bit ci, input logic ei, input bit cs);
    exp_t e;
    addr = a; re = r;
    e.name = nm; e.data = d; e.chk_irq = ci; e.irq = ei; e.chk_seg = cs; e.seg = segs(o0, o1, o2);
    sb.push_back(e);
    req = 1'b1;
    @(posedge clock); #1;
    req = 1'b0; re = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a; datain = d; be = b; we = 1'b1;
    @(posedge clock); #1;
    we = 1'b0; be = 4'hF;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; addr = 32'd0; datain = 32'd0; we = 1'b0; re = 1'b0;
    be = 4'hF; in_port = 10'd0; req = 1'b0;
    o0 = 8'h00; o1 = 8'h00; o2 = 8'h00;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    rd("rst_stat", 32'hC0, 1'b0, 32'h0, 1, 1'b0, 1);
    rd("rst_in1",  32'h84, 1'b0, 32'h0, 0, 1'b0, 0);
    rd("rst_out1", 32'hA4, 1'b0, 32'h0, 0, 1'b0, 0);

    store(32'h0C, 32'hDEADBEEF, 4'hF);
    rd("ram_0c", 32'h0C, 1'b0, 32'hDEADBEEF, 0, 1'b0, 0);
    store(32'h0C, 32'h11223344, 4'b0001);
`ifdef SC_MMIO_BYTE_WRITE_EN
    ram_0c = 32'hDEADBE44;
`else
    ram_0c = 32'h11223344;
`endif
    rd("ram_be", 32'h0C, 1'b0, ram_0c, 0, 1'b0, 0);
    store(32'h00, 32'h12345678, 4'hF);
    store(32'h7C, 32'hCAFEF00D, 4'hF);
    rd("ram_00", 32'h00, 1'b0, 32'h12345678, 0, 1'b0, 0);
    rd("ram_7c", 32'h7C, 1'b0, 32'hCAFEF00D, 0, 1'b0, 0);
    rd("ram_0c_keep", 32'h0C, 1'b0, ram_0c, 0, 1'b0, 0);

    store(32'hA4, 32'h1234563A, 4'hF); o1 = 8'h3A;
    rd("out1", 32'hA4, 1'b0, 32'h3A, 0, 1'b0, 1);
    store(32'hA0, 32'h0000007F, 4'b1110);
`ifdef SC_MMIO_BYTE_WRITE_EN
    o0 = 8'h00;
`else
    o0 = 8'h7F;
`endif
    rd("out0_be", 32'hA0, 1'b0, {24'd0, o0}, 0, 1'b0, 1);
    store(32'hB4, 32'h000000FF, 4'hF);
    rd("out_idx5", 32'hB4, 1'b0, 32'h0, 0, 1'b0, 1);
    store(32'hAC, 32'h000000FF, 4'hF);
    rd("out_idx3", 32'hAC, 1'b0, 32'h0, 0, 1'b0, 1);
    store(32'hE0, 32'hFFFFFFFF, 4'hF);
    rd("rsvd", 32'hE0, 1'b0, 32'h0, 0, 1'b0, 1);
    store(32'hC0, 32'hFFFFFFFF, 4'hF);
    rd("stat_store", 32'hC0, 1'b0, 32'h0, 1, 1'b0, 0);
    store(32'h84, 32'h000000FF, 4'hF);
    rd("in_store", 32'h84, 1'b0, 32'h0, 0, 1'b0, 0);

    in_port = {5'h13, 5'h00};
    rd("sync_e0", 32'h84, 1'b0, 32'h0, 1, 1'b0, 0);
    rd("sync_e1", 32'h84, 1'b0, 32'h0, 1, 1'b0, 0);
    rd("sync_e2", 32'h84, 1'b0, 32'h13, 1, 1'b0, 0);
    rd("stat_e3", 32'hC0, 1'b0, 32'h2, 1, 1'b1, 0);
    rd("stat_clr", 32'hC0, 1'b1, 32'h2, 1, 1'b1, 0);
    rd("stat_after", 32'hC0, 1'b0, 32'h0, 1, 1'b0, 0);

    in_port = {5'h00, 5'h00};
    rd("sw_a", 32'h84, 1'b0, 32'h13, 0, 1'b0, 0);
    in_port = {5'h00, 5'h07};
    rd("sw_b", 32'h80, 1'b0, 32'h0, 1, 1'b0, 0);
    rd("sw_c", 32'h80, 1'b0, 32'h0, 1, 1'b0, 0);
    rd("sw_clr", 32'hC0, 1'b1, 32'h2, 1, 1'b1, 0);
    rd("sw_setwin", 32'hC0, 1'b0, 32'h1, 1, 1'b1, 0);
    rd("sw_clr2", 32'hC0, 1'b1, 32'h1, 1, 1'b1, 0);
    rd("sw_empty", 32'hC0, 1'b0, 32'h0, 1, 1'b0, 0);
    rd("in0_val", 32'h80, 1'b0, 32'h7, 0, 1'b0, 0);

    reset = 1'b1; o0 = 8'h00; o1 = 8'h00; o2 = 8'h00;
    rd("mid_rst", 32'hA4, 1'b0, 32'h0, 1, 1'b0, 1);
    reset = 1'b0;
    rd("rel_e0", 32'hC0, 1'b0, 32'h0, 1, 1'b0, 0);
    rd("rel_e1", 32'h80, 1'b0, 32'h0, 1, 1'b0, 0);
    rd("rel_e2", 32'h80, 1'b0, 32'h7, 1, 1'b0, 0);
    rd("rel_e3", 32'hC0, 1'b0, 32'h1, 1, 1'b1, 0);
    rd("ram_kept", 32'h0C, 1'b0, ram_0c, 0, 1'b0, 1);

    @(negedge clock);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
